// File: rtl/fetch_responder.sv
// -----------------------------------------------------------------------------
// fetch_responder
//   Responder end of the CPU instruction-fetch handshake. Fetch requests are
//   forwarded to an in-order, variable-latency memory backend. The tag of every
//   accepted request is queued in a small FIFO. Each returning backend beat is
//   paired with the tag at the FIFO head. A flush marks all responses still in
//   flight as dropped, so they are consumed without being delivered.
//
// Parameters
//   ADDR_W  fetch word-address width
//   TAG_W   request tag width
//   DEPTH   max outstanding requests (power of two, >= 2)
//
// Ports
//   clk           core clock
//   rst_n         synchronous active-low reset
//   flush         drop responses for every request accepted up to this cycle
//   req_addr      fetch address
//   req_tag       fetch tag
//   req_valid     fetch request present
//   req_accepted  request taken this cycle (combinational)
//   resp_data     instruction word
//   resp_tag      tag paired with resp_data
//   resp_valid    resp_data/resp_tag valid this cycle
//   icache_stall  request present while all DEPTH slots are in flight
//   mem_ren       backend read strobe (combinational)
//   mem_addr      backend address (mirrors req_addr)
//   mem_ready     backend takes mem_ren this cycle
//   mem_rdata     backend data, returned in request order
//   mem_rvalid    backend data beat
//   proto_err     sticky flag: a backend beat arrived with nothing pending
//
// Build option
//   FETCH_RESP_BYPASS_EN : when defined, the response is driven combinationally
//   from the current beat and the FIFO head (zero added latency, outputs read
//   zero when idle). When undefined, the response is registered one cycle
//   after the beat and holds its last value while idle.
// -----------------------------------------------------------------------------
module fetch_responder #(
  parameter int ADDR_W = 27,
  parameter int TAG_W  = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              req_valid,
  output logic              req_accepted,
  output logic [31:0]       resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_valid,
  output logic              icache_stall,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              proto_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PONE_C  = PTR_W'(1);

  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] drop_cnt;
  logic             proto_err_q;

  logic             full;
  logic             accept;
  logic             pop;
  logic             deliver;
  logic [TAG_W-1:0] head_tag;

  // Pointers wrap naturally because DEPTH is a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PONE_C;
  endfunction

  function automatic logic [CNT_W-1:0] pending_next(input logic [CNT_W-1:0] cnt,
                                                    input logic             inc,
                                                    input logic             dec);
    return cnt + CNT_W'(inc) - CNT_W'(dec);
  endfunction

  // ---- stage p0: request side and beat classification (combinational) ----
  // The full check uses pre-pop pending, so a slot freed by this cycle's beat
  // is not reusable until the next cycle. Strobes are held off during reset.
  assign full         = (pending == DEPTH_C);
  assign mem_ren      = rst_n && req_valid && !flush && !full;
  assign mem_addr     = req_addr;
  assign accept       = mem_ren && mem_ready;
  assign req_accepted = accept;
  assign icache_stall = req_valid && full;

  assign pop      = mem_rvalid && (pending != '0);
  assign deliver  = pop && (drop_cnt == '0) && !flush;
  assign head_tag = tag_mem[rd_ptr];

  assign proto_err = proto_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pending     <= '0;
      drop_cnt    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      pending <= pending_next(pending, accept, pop);
      // A flush recomputes the drop count from what is still in flight, so a
      // second flush never double-counts beats already marked as dropped.
      if (flush) begin
        drop_cnt <= pending - CNT_W'(pop);
      end else if (pop && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - ONE_C;
      end
      if (mem_rvalid && (pending == '0)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  // Tag storage carries no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem[wr_ptr] <= req_tag;
    end
  end

`ifdef FETCH_RESP_BYPASS_EN
  assign resp_valid = deliver;
  assign resp_data  = deliver ? mem_rdata : 32'd0;
  assign resp_tag   = deliver ? head_tag  : '0;
`else
  logic             vld_p1;
  logic [31:0]      resp_data_p1;
  logic [TAG_W-1:0] resp_tag_p1;

  // ---- stage p1: registered response ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      resp_data_p1 <= '0;
      resp_tag_p1  <= '0;
    end else begin
      vld_p1 <= deliver;
      if (deliver) begin
        resp_data_p1 <= mem_rdata;
        resp_tag_p1  <= head_tag;
      end
    end
  end

  assign resp_valid = vld_p1;
  assign resp_data  = resp_data_p1;
  assign resp_tag   = resp_tag_p1;
`endif

endmodule

// File: tb/tb_fetch_responder.sv
module tb_fetch_responder;

  localparam int ADDR_W = 27;
  localparam int TAG_W  = 32;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [ADDR_W-1:0] req_addr;
  logic [TAG_W-1:0]  req_tag;
  logic              req_valid;
  logic              req_accepted;
  logic [31:0]       resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_valid;
  logic              icache_stall;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic              proto_err;

  int total;
  int bad;

  fetch_responder #(
    .ADDR_W(ADDR_W),
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_addr    (req_addr),
    .req_tag     (req_tag),
    .req_valid   (req_valid),
    .req_accepted(req_accepted),
    .resp_data   (resp_data),
    .resp_tag    (resp_tag),
    .resp_valid  (resp_valid),
    .icache_stall(icache_stall),
    .mem_ren     (mem_ren),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // mid-cycle, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 27'h100;
    req_tag    = 32'd99;
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;

    // T1: reset held two cycles with a request present
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("t1_accepted", req_accepted, 0);
      check_val("t1_mem_ren", mem_ren, 0);
      check_val("t1_resp_valid", resp_valid, 0);
      check_val("t1_proto_err", proto_err, 0);
      check_val("t1_resp_data", resp_data, 0);
      check_val("t1_resp_tag", resp_tag, 0);
    end
    rst_n     = 1'b1;
    req_valid = 1'b0;
    step();

    // T2: single fetch, 2-cycle backend
    req_valid = 1'b1;
    req_addr  = 27'h100;
    req_tag   = 32'd7;
    settle();
    check_val("t2_accepted", req_accepted, 1);
    check_val("t2_mem_ren", mem_ren, 1);
    check_val("t2_mem_addr", mem_addr, 27'h100);
    check_val("t2_stall", icache_stall, 0);
    step();
    req_valid = 1'b0;
    settle();
    check_val("t2_idle_c1", resp_valid, 0);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    settle();
    check_val("t2_not_yet_c2", resp_valid, 0);
    step();
    mem_rvalid = 1'b0;
    settle();
    check_val("t2_valid_c3", resp_valid, 1);
    check_val("t2_data_c3", resp_data, 32'hDEADBEEF);
    check_val("t2_tag_c3", resp_tag, 7);
    step();
    check_val("t2_valid_c4", resp_valid, 0);
    check_val("t2_hold_data", resp_data, 32'hDEADBEEF);
    check_val("t2_hold_tag", resp_tag, 7);

    // T3: fill to DEPTH with a mute backend, then stall
    for (int t = 1; t <= 4; t++) begin
      req_valid = 1'b1;
      req_tag   = t;
      req_addr  = 27'h200 + t;
      settle();
      check_val("t3_fill_accept", req_accepted, 1);
      step();
    end
    req_tag    = 32'd5;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA1;
    settle();
    check_val("t3_stall", icache_stall, 1);
    check_val("t3_no_accept", req_accepted, 0);
    check_val("t3_no_ren", mem_ren, 0);
    step();
    mem_rvalid = 1'b0;
    settle();
    check_val("t3_accept_5", req_accepted, 1);
    check_val("t3_stall_clear", icache_stall, 0);
    check_val("t3_resp_valid_1", resp_valid, 1);
    check_val("t3_resp_tag_1", resp_tag, 1);
    check_val("t3_resp_data_1", resp_data, 32'hA1);
    step();
    req_valid = 1'b0;
    settle();
    check_val("t3_no_stall_idle", icache_stall, 0);

    // drain tags 2..5 with back-to-back beats
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hB0 + i;
      settle();
      if (i == 0) begin
        check_val("drain_first_idle", resp_valid, 0);
      end else begin
        check_val("drain_valid", resp_valid, 1);
        check_val("drain_tag", resp_tag, i + 1);
        check_val("drain_data", resp_data, 32'hB0 + i - 1);
      end
      step();
    end
    mem_rvalid = 1'b0;
    settle();
    check_val("drain_last_valid", resp_valid, 1);
    check_val("drain_last_tag", resp_tag, 5);
    check_val("drain_last_data", resp_data, 32'hB3);
    step();

    // T4: flush with tags 10,11,12 outstanding
    for (int t = 10; t <= 12; t++) begin
      req_valid = 1'b1;
      req_tag   = t;
      settle();
      check_val("t4_accept", req_accepted, 1);
      step();
    end
    flush      = 1'b1;
    req_tag    = 32'd99;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hC10;
    settle();
    check_val("t4_flush_block", req_accepted, 0);
    check_val("t4_flush_ren", mem_ren, 0);
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    mem_rdata = 32'hC11;
    settle();
    check_val("t4_drop_10", resp_valid, 0);
    step();
    mem_rdata = 32'hC12;
    settle();
    check_val("t4_drop_11", resp_valid, 0);
    step();
    mem_rvalid = 1'b0;
    settle();
    check_val("t4_drop_12", resp_valid, 0);
    req_valid = 1'b1;
    req_tag   = 32'd13;
    settle();
    check_val("t4_accept_13", req_accepted, 1);
    step();
    req_valid  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hC13;
    settle();
    check_val("t4_no_err", proto_err, 0);
    step();
    mem_rvalid = 1'b0;
    settle();
    check_val("t4_valid_13", resp_valid, 1);
    check_val("t4_tag_13", resp_tag, 13);
    check_val("t4_data_13", resp_data, 32'hC13);
    step();

    // T5: spurious beat with nothing pending
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hEE;
    settle();
    check_val("t5_err_before", proto_err, 0);
    step();
    mem_rvalid = 1'b0;
    settle();
    check_val("t5_err_set", proto_err, 1);
    check_val("t5_no_resp", resp_valid, 0);
    step();
    check_val("t5_err_sticky", proto_err, 1);
    check_val("t5_no_resp2", resp_valid, 0);

    // T6: back-to-back beats for tags 20, 21
    for (int t = 20; t <= 21; t++) begin
      req_valid = 1'b1;
      req_tag   = t;
      settle();
      check_val("t6_accept", req_accepted, 1);
      step();
    end
    req_valid = 1'b0;
`ifdef FETCH_RESP_BYPASS_EN
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5020;
    settle();
    check_val("t6_valid_20", resp_valid, 1);
    check_val("t6_tag_20", resp_tag, 20);
    check_val("t6_data_20", resp_data, 32'h5020);
    step();
    mem_rdata = 32'h5021;
    settle();
    check_val("t6_valid_21", resp_valid, 1);
    check_val("t6_tag_21", resp_tag, 21);
    check_val("t6_data_21", resp_data, 32'h5021);
    step();
    mem_rvalid = 1'b0;
    settle();
    check_val("t6_idle_valid", resp_valid, 0);
    check_val("t6_idle_data", resp_data, 0);
    check_val("t6_idle_tag", resp_tag, 0);
`else
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5020;
    settle();
    check_val("t6_reg_lag", resp_valid, 0);
    step();
    mem_rdata = 32'h5021;
    settle();
    check_val("t6_valid_20", resp_valid, 1);
    check_val("t6_tag_20", resp_tag, 20);
    check_val("t6_data_20", resp_data, 32'h5020);
    step();
    mem_rvalid = 1'b0;
    settle();
    check_val("t6_valid_21", resp_valid, 1);
    check_val("t6_tag_21", resp_tag, 21);
    check_val("t6_data_21", resp_data, 32'h5021);
    step();
    check_val("t6_idle_valid", resp_valid, 0);
    check_val("t6_hold_tag", resp_tag, 21);
`endif

    // reset clears the sticky error
    rst_n = 1'b0;
    step();
    check_val("rst_clears_err", proto_err, 0);
    check_val("rst_clears_tag", resp_tag, 0);
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
